// File: rtl/bcd_stopwatch.sv
// bcd_stopwatch: BCD stopwatch / countdown timer with an internal prescaler.
//
// Parameters:
//   DIGITS    number of BCD digits (2..8)
//   TICK_DIV  clk cycles per least-significant count (>= 1)
// Ports:
//   clk, rst  rising-edge clock, asynchronous active-high reset
//   cmd       00 none, 01 clear, 10 start/resume, 11 stop/pause (level)
//   dir       0 up, 1 down; latched only on a start from IDLE
//   load      preset strobe, load_val holds the preset (digit 0 in [3:0])
//   lap       lap-freeze toggle strobe (honoured in RUN only)
//   digits    displayed BCD value (lap value while frozen)
//   running   high while in RUN
//   done      one-cycle pulse when a down count reaches zero
//   wrap      sticky flag, set when an up count rolls over from all-9s

// Per-digit cell: increment/decrement with ripple carry/borrow, plus
// saturation of a preset digit to 9.
module bcd_digit (
  input  logic [3:0] d,
  input  logic       cin,
  input  logic       bin,
  input  logic [3:0] ld,
  output logic [3:0] inc,
  output logic       cout,
  output logic [3:0] dec,
  output logic       bout,
  output logic [3:0] ld_sat
);
  always_comb begin
    inc    = cin ? ((d == 4'd9) ? 4'd0 : d + 4'd1) : d;
    cout   = cin && (d == 4'd9);
    dec    = bin ? ((d == 4'd0) ? 4'd9 : d - 4'd1) : d;
    bout   = bin && (d == 4'd0);
    ld_sat = (ld > 4'd9) ? 4'd9 : ld;
  end
endmodule

module bcd_stopwatch #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            cmd,
  input  logic                  dir,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  lap,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  running,
  output logic                  done,
  output logic                  wrap
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  localparam logic [1:0] CMD_CLEAR = 2'b01;
  localparam logic [1:0] CMD_START = 2'b10;
  localparam logic [1:0] CMD_STOP  = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  state_t                  state_q, state_d;
  logic [DIGITS-1:0][3:0]  cnt_q, cnt_d, lap_q, lap_d, digits_q, digits_d;
  logic [PW-1:0]           pre_q, pre_d;
  logic                    dir_q, dir_d;
  logic                    frozen_q, frozen_d;
  logic                    wrap_q, wrap_d;
  logic                    done_q, done_d;
  logic                    running_q, running_d;

  logic [DIGITS-1:0][3:0]  inc_val, dec_val, ld_in, ld_sat;
  logic [DIGITS:0]         carry, borrow;
  logic                    tick;

  assign carry[0]  = 1'b1;
  assign borrow[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    assign ld_in[g] = load_val[4*g +: 4];
    bcd_digit u_dig (
      .d      (cnt_q[g]),
      .cin    (carry[g]),
      .bin    (borrow[g]),
      .ld     (ld_in[g]),
      .inc    (inc_val[g]),
      .cout   (carry[g+1]),
      .dec    (dec_val[g]),
      .bout   (borrow[g+1]),
      .ld_sat (ld_sat[g])
    );
  end

  assign tick = (state_q == RUN) && (pre_q == PRE_MAX);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pre_d    = pre_q;
    dir_d    = dir_q;
    lap_d    = lap_q;
    frozen_d = frozen_q;
    wrap_d   = wrap_q;
    done_d   = 1'b0;

    if (cmd == CMD_CLEAR) begin
      state_d  = IDLE;
      cnt_d    = '0;
      pre_d    = '0;
      frozen_d = 1'b0;
      wrap_d   = 1'b0;
    end else if (load && state_q != RUN) begin
      // Load takes the cycle: start/stop alongside it are not acted on.
      cnt_d = ld_sat;
      if (state_q == DONE) state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          // A down count from zero would finish immediately; refuse it.
          if (cmd == CMD_START && !(dir && cnt_q == '0)) begin
            state_d = RUN;
            dir_d   = dir;
            pre_d   = '0;
          end
        end
        RUN: begin
          pre_d = tick ? '0 : pre_q + PW'(1);
          if (lap) begin
            if (frozen_q) frozen_d = 1'b0;
            else begin
              lap_d    = cnt_q;
              frozen_d = 1'b1;
            end
          end
          if (cmd == CMD_STOP) state_d = PAUSED;
          if (tick) begin
            if (dir_q) begin
              cnt_d = dec_val;
              if (dec_val == '0) begin
                done_d  = 1'b1;
                state_d = DONE;
              end
            end else begin
              cnt_d = inc_val;
              if (carry[DIGITS]) wrap_d = 1'b1;
            end
          end
        end
        PAUSED: begin
          // pre is kept so a partial tick period resumes where it stopped.
          if (cmd == CMD_START) state_d = RUN;
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end

    running_d = (state_d == RUN);
    digits_d  = frozen_d ? lap_d : cnt_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      lap_q     <= '0;
      digits_q  <= '0;
      pre_q     <= '0;
      dir_q     <= 1'b0;
      frozen_q  <= 1'b0;
      wrap_q    <= 1'b0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lap_q     <= lap_d;
      digits_q  <= digits_d;
      pre_q     <= pre_d;
      dir_q     <= dir_d;
      frozen_q  <= frozen_d;
      wrap_q    <= wrap_d;
      done_q    <= done_d;
      running_q <= running_d;
    end
  end

  assign digits  = digits_q;
  assign running = running_q;
  assign done    = done_q;
  assign wrap    = wrap_q;
endmodule

// File: tb/tb_bcd_stopwatch.sv
`timescale 1ns/1ps
// Scoreboard bench for bcd_stopwatch (DIGITS=4, TICK_DIV=4). Stimulus pushes
// expected outputs tagged with the clk edge after which they must hold; the
// monitor samples on the falling edge and checks every entry due then.
module tb_bcd_stopwatch;
  localparam logic [1:0] C_CLEAR = 2'b01;
  localparam logic [1:0] C_START = 2'b10;
  localparam logic [1:0] C_STOP  = 2'b11;
  localparam logic [3:0] M_ALL   = 4'hF;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cmd;
  logic        dir, load, lap;
  logic [15:0] load_val;
  logic [15:0] digits;
  logic        running, done, wrap;

  bcd_stopwatch #(.DIGITS(4), .TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .dir(dir), .load(load),
    .load_val(load_val), .lap(lap), .digits(digits), .running(running),
    .done(done), .wrap(wrap)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          tag;
    string       name;
    logic [15:0] dig;
    logic        run, dn, wr;
    logic [3:0]  m;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic push(input int tag, input string nm, input logic [15:0] dg,
                      input logic r, input logic d, input logic w);
    exp_t e;
    int   i;
    e.tag = tag; e.name = nm; e.dig = dg; e.run = r; e.dn = d; e.wr = w;
    e.m = M_ALL;
    i = 0;
    while (i < sb.size() && sb[i].tag <= tag) i++;
    sb.insert(i, e);
  endtask

  // Monitor
  initial begin
    exp_t e;
    logic ok;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].tag <= cyc) begin
        e = sb.pop_front();
        total++;
        if (e.tag < cyc) begin
          bad++;
          $display("FAIL %s: check missed, due at edge %0d, now %0d", e.name, e.tag, cyc);
        end else begin
          ok = 1'b1;
          if (e.m[3] && digits  !== e.dig) ok = 1'b0;
          if (e.m[2] && running !== e.run) ok = 1'b0;
          if (e.m[1] && done    !== e.dn)  ok = 1'b0;
          if (e.m[0] && wrap    !== e.wr)  ok = 1'b0;
          if (!ok) begin
            bad++;
            $display("FAIL %s @%0d: got digits=%h running=%b done=%b wrap=%b, want digits=%h running=%b done=%b wrap=%b",
                     e.name, cyc, digits, running, done, wrap, e.dig, e.run, e.dn, e.wr);
          end
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_cmd(input logic [1:0] c);
    cmd = c;
    @(negedge clk);
    cmd = 2'b00;
  endtask

  task automatic drive_load(input logic [15:0] v);
    load = 1'b1; load_val = v;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic drive_lap;
    lap = 1'b1;
    @(negedge clk);
    lap = 1'b0;
  endtask

  // Stimulus
  initial begin
    int k, r, l;
    rst = 1'b1; cmd = 2'b00; dir = 1'b0; load = 1'b0; lap = 1'b0; load_val = '0;
    wait_cyc(3);
    push(cyc + 1, "reset", 16'h0000, 0, 0, 0);
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(1);

    // Up count from reset
    k = cyc + 1; dir = 1'b0;
    push(k,      "up_start", 16'h0000, 1, 0, 0);
    push(k + 3,  "up_pre",   16'h0000, 1, 0, 0);
    push(k + 4,  "up_first", 16'h0001, 1, 0, 0);
    push(k + 40, "up_40",    16'h0010, 1, 0, 0);
    drive_cmd(C_START);
    wait_cyc(40);
    k = cyc + 1;
    push(k, "up_clear", 16'h0000, 0, 0, 0);
    drive_cmd(C_CLEAR);

    // Wrap
    k = cyc + 1;
    push(k, "wrap_load", 16'h9998, 0, 0, 0);
    drive_load(16'h9998);
    k = cyc + 1;
    push(k + 3, "wrap_pre",  16'h9998, 1, 0, 0);
    push(k + 4, "wrap_9999", 16'h9999, 1, 0, 0);
    push(k + 7, "wrap_hold", 16'h9999, 1, 0, 0);
    push(k + 8, "wrap_roll", 16'h0000, 1, 0, 1);
    drive_cmd(C_START);
    wait_cyc(9);
    k = cyc + 1;
    push(k, "wrap_clear", 16'h0000, 0, 0, 0);
    drive_cmd(C_CLEAR);
    // Down start from zero is refused
    k = cyc + 1; dir = 1'b1;
    push(k + 1, "dn_zero_ign", 16'h0000, 0, 0, 0);
    drive_cmd(C_START);
    wait_cyc(2);

    // Countdown
    k = cyc + 1;
    push(k, "cd_load", 16'h0003, 0, 0, 0);
    drive_load(16'h0003);
    k = cyc + 1; dir = 1'b1;
    push(k + 4,  "cd_2",      16'h0002, 1, 0, 0);
    push(k + 8,  "cd_1",      16'h0001, 1, 0, 0);
    push(k + 11, "cd_pre0",   16'h0001, 1, 0, 0);
    push(k + 12, "cd_done",   16'h0000, 0, 1, 0);
    push(k + 13, "cd_after",  16'h0000, 0, 0, 0);
    drive_cmd(C_START);
    wait_cyc(14);
    k = cyc + 1; dir = 1'b0;
    push(k + 4, "done_start_ign", 16'h0000, 0, 0, 0);
    drive_cmd(C_START);
    wait_cyc(5);
    k = cyc + 1;
    push(k, "done_load", 16'h0010, 0, 0, 0);
    drive_load(16'h0010);
    k = cyc + 1;
    push(k, "idle_start", 16'h0010, 1, 0, 0);
    drive_cmd(C_START);
    wait_cyc(1);
    k = cyc + 1;
    push(k, "cd_clear", 16'h0000, 0, 0, 0);
    drive_cmd(C_CLEAR);

    // Pause / resume
    k = cyc + 1; dir = 1'b0;
    push(k, "p_start", 16'h0000, 1, 0, 0);
    drive_cmd(C_START);
    wait_cyc(1);
    k = cyc + 1;
    push(k,       "p_stop", 16'h0000, 0, 0, 0);
    push(k + 100, "p_hold", 16'h0000, 0, 0, 0);
    drive_cmd(C_STOP);
    wait_cyc(100);
    r = cyc + 1;
    push(r,     "r_run",   16'h0000, 1, 0, 0);
    push(r + 1, "r_pre",   16'h0000, 1, 0, 0);
    push(r + 2, "r_inc",   16'h0001, 1, 0, 0);
    push(r + 5, "r_hold",  16'h0001, 1, 0, 0);
    push(r + 6, "r_inc2",  16'h0002, 1, 0, 0);
    drive_cmd(C_START);
    wait_cyc(7);
    k = cyc + 1;
    push(k, "p2_stop", 16'h0002, 0, 0, 0);
    drive_cmd(C_STOP);
    k = cyc + 1;
    push(k, "p_load_sat", 16'h0091, 0, 0, 0);
    drive_load(16'h00A1);
    k = cyc + 1;
    push(k, "p_clear", 16'h0000, 0, 0, 0);
    drive_cmd(C_CLEAR);

    // Lap freeze
    k = cyc + 1;
    push(k + 20, "lap_cnt5", 16'h0005, 1, 0, 0);
    drive_cmd(C_START);
    wait_cyc(20);
    l = cyc + 1;
    push(l,      "lap_frz",   16'h0005, 1, 0, 0);
    push(l + 10, "lap_hold",  16'h0005, 1, 0, 0);
    push(l + 19, "lap_hold2", 16'h0005, 1, 0, 0);
    push(l + 20, "lap_rel",   16'h0010, 1, 0, 0);
    push(k + 44, "lap_live",  16'h0011, 1, 0, 0);
    drive_lap();
    wait_cyc(19);
    drive_lap();
    wait_cyc(5);

    // Async reset between edges while running
    @(posedge clk);
    #2;
    push(cyc, "async_rst", 16'h0000, 0, 0, 0);
    rst = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    k = cyc + 1;
    push(k + 3, "rst_pre", 16'h0000, 1, 0, 0);
    push(k + 4, "rst_cnt", 16'h0001, 1, 0, 0);
    drive_cmd(C_START);
    wait_cyc(6);

    for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clk);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      total++;
      bad++;
      $display("FAIL %s: never checked, due at edge %0d", e.name, e.tag);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bcd_stopwatch.md
# bcd_stopwatch

Parametrised BCD stopwatch/countdown timer, the successor to the fixed three-digit timer. It counts at a rate set by an internal prescaler, so no external slow clock is needed. It supports up or down counting, preset load, pause/resume and a lap-freeze display. Its digit bus feeds the seven-segment display driver directly.

## Interface
- DIGITS, 4, number of BCD digits, legal range 2..8
- TICK_DIV, 100000, clk cycles per least-significant count, ≥1
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- cmd  in  2  00 none, 01 clear, 10 start/resume, 11 stop/pause; level-sampled every cycle
- dir  in  1  0 = count up, 1 = count down; latched only on start from IDLE
- load  in  1  preset strobe
- load_val  in  4*DIGITS  preset value, digit 0 in bits [3:0]
- lap  in  1  lap-freeze toggle strobe
- digits  out  4*DIGITS  displayed BCD value
- running  out  1  high while in RUN
- done  out  1  one-cycle pulse when a down count reaches zero
- wrap  out  1  sticky flag, set when an up count rolls over from all-9s

## Operation
- State register values: IDLE, RUN, PAUSED, DONE.
- Internal registers:
  - cnt: BCD, DIGITS digits
  - pre: prescaler, width $clog2(TICK_DIV), minimum 1
  - dir_q: latched direction
  - lap_q: captured lap value
  - frozen: lap-freeze flag
- Tick: asserted when state is RUN and pre == TICK_DIV-1.
  - pre returns to 0 on a tick and increments otherwise while in RUN.
  - pre holds its value in PAUSED.
- Up tick: BCD increment with ripple carry, each digit 9→0 carrying into the next.
  - All-9s → all-0 and wrap is set.
  - Counting continues after a wrap.
- Down tick: BCD decrement with ripple borrow, each digit 0→9 borrowing from the next.
  - If the result is all-0: done pulses, running drops, state becomes DONE.
- Transitions:
  - IDLE:
    - start → RUN; latch dir_q, pre=0.
    - start with dir=1 and cnt==0 is ignored (stays IDLE).
  - RUN:
    - stop → PAUSED.
    - tick updates cnt.
    - load is ignored.
  - PAUSED:
    - start → RUN; pre is not cleared, so a partial tick resumes.
    - dir is not relatched.
  - DONE:
    - start and stop are ignored.
    - load → IDLE.
  - Any state: clear → IDLE; cnt=0, pre=0, frozen=0, wrap=0.
- Load, accepted in IDLE, PAUSED and DONE: cnt=load_val.
  - Any digit >9 is saturated to 9.
  - wrap is not cleared by load.
- Priority in the same cycle: clear > load > tick > stop/start.
  - A tick coinciding with stop is applied, then state becomes PAUSED.
- Lap, honoured in RUN only:
  - If not frozen: lap_q=cnt, frozen=1.
  - If frozen: frozen=0.
  - Lap is ignored in other states; frozen persists through PAUSED.
- digits = frozen ? lap_q : cnt, registered.

## Timing
- Reset (async assert, sync-style release): state IDLE; cnt, lap_q and digits all 0; pre 0; running 0; done 0; wrap 0; frozen 0.
- Reset mid-RUN clears all outputs immediately, without waiting for a clk edge.
- Start sampled at edge k: running=1 after edge k.
  - First cnt change at edge k+TICK_DIV.
  - Later changes every TICK_DIV cycles.
- digits reflects a cnt change at the same edge; there is no extra pipeline stage.
- done is high for exactly one cycle, coincident with digits becoming 0 and running going 0.
- TICK_DIV=1: cnt changes on every RUN cycle.
- Commands and strobes act at the edge on which they are sampled.
- A command held for multiple cycles is idempotent, except lap, which toggles every cycle it is high (callers must pulse it).

## Test plan
All scenarios use DIGITS=4, TICK_DIV=4.

- **Up count:** start with dir=0 from reset, run 40 cycles. Required: digits 0x0010, running 1, wrap 0.
- **Wrap:** load 0x9998, start up, run 8 cycles. Required: digits 0x9999 at cycle 4, then 0x0000 at cycle 8 with wrap=1. Then clear: wrap=0, state IDLE.
- **Countdown:** load 0x0003, dir=1, start. Required:
  - digits 0x0000 at cycle 12; done high exactly that cycle; running 0.
  - A subsequent start is ignored.
  - A subsequent load of 0x0010 returns the block to IDLE with digits 0x0010.
- **Pause/resume:**
  - Stop 2 cycles into a tick period, hold 100 cycles: digits unchanged.
  - Resume: next increment exactly 2 cycles later.
  - Load 0x00A1 while paused: digits 0x0091.
- **Lap:**
  - At count 0x0005, pulse lap: digits hold 0x0005 while cnt advances.
  - After 20 cycles, pulse lap: digits 0x0010.
- **Async reset mid-RUN:** assert rst between clk edges. Required: digits, running, done and wrap all 0 before the next edge. After release, start resumes counting from 0.
